pursuit_iteration_sequencer: RTL and testbench

//  Parametrised iteration controller for greedy pursuit engines (MP, OMP, CoSaMP).

---
 rtl/pursuit_iteration_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_pursuit_iteration_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pursuit_iteration_sequencer.sv
// pursuit_iteration_sequencer
//   Iteration controller for greedy pursuit engines (MP / OMP / CoSaMP).
//   A run is up to max_iter iterations. Each iteration steps through NUM_PHASES
//   phases. A phase is either timed (phase_cycles+1 RUN cycles) or handshaked
//   (it ends on phase_ack). A run can stop early on converged, or be cancelled
//   with abort.
//
//   Optional feature macro: PURSUIT_WATCHDOG_EN
//     defined   : a watchdog bounds each handshaked phase to WDOG_CYCLES cycles.
//                 On expiry the run returns to IDLE and pulses timeout and aborted.
//     undefined : there is no watchdog, timeout is tied low, and handshaked
//                 phases can wait forever.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; configuration shadow registers hold last run
//   LAUNCH | first cycle of a phase; loads the phase down-counter
//   RUN    | phase body; timed = count down to 0, handshaked = wait for ack
//   NEXT   | end of iteration; bump iter_count, decide finish or next pass
//   FINISH | one-cycle done pulse, then back to IDLE

module pursuit_iteration_sequencer #(
   parameter int NUM_PHASES  = 4,
   parameter int CNT_W       = 16,
   parameter int ITER_W      = 8,
   parameter int WDOG_CYCLES = 4096
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           abort,
   input  logic [ITER_W-1:0]              max_iter,
   input  logic [NUM_PHASES*CNT_W-1:0]    phase_cycles,
   input  logic [NUM_PHASES-1:0]          phase_hs,
   input  logic                           phase_ack,
   input  logic                           converged,
   output logic                           busy,
   output logic                           phase_start,
   output logic [((NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1)-1:0] phase_idx,
   output logic [ITER_W-1:0]              iter_count,
   output logic                           done,
   output logic                           early_stop,
   output logic                           aborted,
   output logic                           timeout
);

   localparam int PIDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
   localparam logic [PIDX_W-1:0] LAST_PHASE = PIDX_W'(NUM_PHASES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_RUN    = 3'd2,
      S_NEXT   = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   state_t state;
   state_t next_state;

   logic [ITER_W-1:0]           max_iter_q;
   logic [NUM_PHASES*CNT_W-1:0] phase_cycles_q;
   logic [NUM_PHASES-1:0]       phase_hs_q;
   logic [CNT_W-1:0]            cnt;
   logic [CNT_W-1:0]            cycles_arr [NUM_PHASES];

   logic              cur_hs;
   logic              phase_end;
   logic              in_run;
   logic              abort_hit;
   logic              finish_iter;
   logic              wdog_expire;
   logic [ITER_W-1:0] iter_inc;

   logic busy_d;
   logic phase_start_d;
   logic done_d;
   logic aborted_d;
   logic timeout_d;

   // unpack the captured per-phase counts so the current one can be indexed
   always_comb begin
      for (int i = 0; i < NUM_PHASES; i++) begin
         cycles_arr[i] = phase_cycles_q[i*CNT_W +: CNT_W];
      end
   end

   // per-cycle decision terms shared by next-state and datapath logic
   always_comb begin
      in_run      = (state == S_RUN);
      cur_hs      = phase_hs_q[phase_idx];
      phase_end   = in_run && (cur_hs ? phase_ack : (cnt == '0));
      abort_hit   = (state != S_IDLE) && abort;
      iter_inc    = iter_count + 1'b1;
      finish_iter = (iter_inc == max_iter_q) || converged;
   end

`ifdef PURSUIT_WATCHDOG_EN
   localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

   logic [WD_W-1:0] wdog_cnt;

   // watchdog: cleared at each phase launch, counts unacknowledged handshake cycles
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wdog_cnt <= '0;
      end else if (state == S_LAUNCH) begin
         wdog_cnt <= '0;
      end else if (in_run && cur_hs && !phase_ack) begin
         wdog_cnt <= wdog_cnt + 1'b1;
      end
   end

   // expiry fires in the WDOG_CYCLES-th handshaked RUN cycle without ack
   always_comb begin
      wdog_expire = in_run && cur_hs && !phase_ack && (wdog_cnt == WD_LAST);
   end
`else
   // keeps the watchdog parameter referenced in builds without the watchdog
   logic unused_wdog;
   assign unused_wdog = ^WDOG_CYCLES;

   // no watchdog: handshaked phases wait indefinitely
   always_comb begin
      wdog_expire = 1'b0;
   end
`endif

   // state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // next-state logic; abort overrides every other transition
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               next_state = (max_iter == '0) ? S_FINISH : S_LAUNCH;
            end
         end
         S_LAUNCH: next_state = S_RUN;
         S_RUN: begin
            if (phase_end) begin
               next_state = (phase_idx == LAST_PHASE) ? S_NEXT : S_LAUNCH;
            end else if (wdog_expire) begin
               next_state = S_IDLE;
            end
         end
         S_NEXT:   next_state = finish_iter ? S_FINISH : S_LAUNCH;
         S_FINISH: next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
      if (abort_hit) begin
         next_state = S_IDLE;
      end
   end

   // output decode from the next state, registered below
   always_comb begin
      busy_d        = (next_state != S_IDLE);
      phase_start_d = (next_state == S_LAUNCH);
      done_d        = (next_state == S_FINISH);
      aborted_d     = abort_hit || wdog_expire;
      timeout_d     = wdog_expire;
   end

   // registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy        <= 1'b0;
         phase_start <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         busy        <= busy_d;
         phase_start <= phase_start_d;
         done        <= done_d;
         aborted     <= aborted_d;
         timeout     <= timeout_d;
      end
   end

   // configuration capture, phase counter, phase index and iteration bookkeeping
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         max_iter_q     <= '0;
         phase_cycles_q <= '0;
         phase_hs_q     <= '0;
         cnt            <= '0;
         phase_idx      <= '0;
         iter_count     <= '0;
         early_stop     <= 1'b0;
      end else if (abort_hit || wdog_expire) begin
         // cancelled runs keep iter_count so software can see how far they got
         phase_idx <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  max_iter_q     <= max_iter;
                  phase_cycles_q <= phase_cycles;
                  phase_hs_q     <= phase_hs;
                  phase_idx      <= '0;
                  iter_count     <= '0;
                  early_stop     <= 1'b0;
               end
            end
            S_LAUNCH: begin
               cnt <= cycles_arr[phase_idx];
            end
            S_RUN: begin
               if (!cur_hs && (cnt != '0)) begin
                  cnt <= cnt - 1'b1;
               end
               if (phase_end && (phase_idx != LAST_PHASE)) begin
                  phase_idx <= phase_idx + 1'b1;
               end
            end
            S_NEXT: begin
               iter_count <= iter_inc;
               if (finish_iter) begin
                  early_stop <= converged;
               end else begin
                  phase_idx <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pursuit_iteration_sequencer.sv
// Directed bench for pursuit_iteration_sequencer (NUM_PHASES=4, CNT_W=16, ITER_W=8).
// Samples outputs on the falling edge; "sample k" is the falling edge after the
// k-th rising edge following the start-accept edge (sample 0).
module tb_pursuit_iteration_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [7:0]  max_iter;
   logic [63:0] phase_cycles;
   logic [3:0]  phase_hs;
   logic        phase_ack;
   logic        converged;
   logic        busy;
   logic        phase_start;
   logic [1:0]  phase_idx;
   logic [7:0]  iter_count;
   logic        done;
   logic        early_stop;
   logic        aborted;
   logic        timeout;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   pursuit_iteration_sequencer #(
      .NUM_PHASES(4), .CNT_W(16), .ITER_W(8), .WDOG_CYCLES(16)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .max_iter(max_iter), .phase_cycles(phase_cycles), .phase_hs(phase_hs),
      .phase_ack(phase_ack), .converged(converged), .busy(busy),
      .phase_start(phase_start), .phase_idx(phase_idx), .iter_count(iter_count),
      .done(done), .early_stop(early_stop), .aborted(aborted), .timeout(timeout)
   );

   // Starts a run (caller sits at a falling edge) and counts cycles until done.
   // done_k = -1 if done never appears within the budget.
   task automatic run_seq(input logic [7:0] mi, input logic [63:0] pc, input logic [3:0] hs,
                          input int restart_at, output int done_k, output int ps_cnt);
      max_iter = mi; phase_cycles = pc; phase_hs = hs;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      done_k = -1; ps_cnt = 0;
      for (int k = 0; k < 3000; k++) begin
         if (phase_start) ps_cnt++;
         if (done) begin
            done_k = k;
            break;
         end
         start = (k == restart_at);
         @(negedge clock);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 0; abort = 0; max_iter = 0; phase_cycles = 0;
      phase_hs = 0; phase_ack = 0; converged = 0;
      repeat (3) @(negedge clock);
      n_checks++;
      if ({busy, phase_start, phase_idx, iter_count, done, early_stop, aborted, timeout} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b ps=%b idx=%0d iter=%0d done=%b es=%b ab=%b to=%b, want all 0",
                  busy, phase_start, phase_idx, iter_count, done, early_stop, aborted, timeout);
      end
      reset = 1'b0;
      @(negedge clock);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_reset: busy=%b want 0", busy);
      end
   endtask

   task automatic test_all_timed();
      int dk, pc;
      run_seq(8'd3, {4{16'd2}}, 4'b0000, 5, dk, pc);
      n_checks++;
      if (dk !== 51) begin n_fail++; $display("FAIL timed_done_edge: got %0d want 51", dk); end
      n_checks++;
      if (pc !== 12) begin n_fail++; $display("FAIL timed_phase_starts: got %0d want 12", pc); end
      n_checks++;
      if (iter_count !== 8'd3) begin n_fail++; $display("FAIL timed_iter_count: got %0d want 3", iter_count); end
      n_checks++;
      if (early_stop !== 1'b0) begin n_fail++; $display("FAIL timed_early_stop: got %b want 0", early_stop); end
      @(negedge clock);
      n_checks++;
      if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL timed_back_idle: busy/done=%b want 00", {busy, done}); end
   endtask

   task automatic test_phase_walk();
      // cycles=2, max_iter=3: phase 1 launches at sample 4, iteration 2 at sample 17
      max_iter = 8'd3; phase_cycles = {4{16'd2}}; phase_hs = 4'b0000;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int k = 0; k < 18; k++) begin
         if (k == 4) begin
            n_checks++;
            if ({phase_start, phase_idx} !== 3'b1_01) begin
               n_fail++; $display("FAIL walk_phase1_launch: ps/idx=%b want 101", {phase_start, phase_idx});
            end
         end
         if (k == 17) begin
            n_checks++;
            if ({phase_start, phase_idx, iter_count} !== {1'b1, 2'd0, 8'd1}) begin
               n_fail++; $display("FAIL walk_iter2_launch: ps=%b idx=%0d iter=%0d want 1 0 1",
                                  phase_start, phase_idx, iter_count);
            end
         end
         @(negedge clock);
      end
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_mixed_cycles();
      int dk, pc;
      // phase counts 5,0,1,3 -> 18 cycles per iteration, two iterations
      run_seq(8'd2, {16'd3, 16'd1, 16'd0, 16'd5}, 4'b0000, -1, dk, pc);
      n_checks++;
      if (dk !== 36) begin n_fail++; $display("FAIL mixed_done_edge: got %0d want 36", dk); end
      n_checks++;
      if (pc !== 8) begin n_fail++; $display("FAIL mixed_phase_starts: got %0d want 8", pc); end
      @(negedge clock);
      run_seq(8'd1, 64'd0, 4'b0000, -1, dk, pc);
      n_checks++;
      if (dk !== 9) begin n_fail++; $display("FAIL zero_cycles_done_edge: got %0d want 9", dk); end
      n_checks++;
      if (iter_count !== 8'd1) begin n_fail++; $display("FAIL zero_cycles_iter: got %0d want 1", iter_count); end
      @(negedge clock);
   endtask

   task automatic test_zero_iter();
      max_iter = 8'd0; phase_cycles = {4{16'd2}}; phase_hs = 4'b0000;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      n_checks++;
      if ({done, phase_start, iter_count} !== {1'b1, 1'b0, 8'd0}) begin
         n_fail++; $display("FAIL zero_iter_done: done=%b ps=%b iter=%0d want 1 0 0", done, phase_start, iter_count);
      end
      @(negedge clock);
      n_checks++;
      if ({busy, done, phase_start} !== 3'b000) begin
         n_fail++; $display("FAIL zero_iter_after: busy/done/ps=%b want 000", {busy, done, phase_start});
      end
   endtask

   task automatic test_handshake();
      int p1 = -1, p2 = -1, dk = -1;
      // ack outside RUN while idle must not start anything
      phase_ack = 1'b1;
      @(negedge clock);
      phase_ack = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL hs_idle_ack: busy=%b want 0", busy); end
      max_iter = 8'd1; phase_cycles = {4{16'd1}}; phase_hs = 4'b0010;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (phase_start && phase_idx == 2'd1 && p1 < 0) p1 = k;
         if (phase_start && phase_idx == 2'd2 && p2 < 0) p2 = k;
         if (done) begin dk = k; break; end
         // stray ack in timed phase 0 and in the LAUNCH of phase 1; real ack in RUN cycle 10
         phase_ack = (k == 1) || (k == 3) || (k == 13);
         @(negedge clock);
      end
      phase_ack = 1'b0;
      n_checks++;
      if (p1 !== 3) begin n_fail++; $display("FAIL hs_phase1_launch: got %0d want 3", p1); end
      n_checks++;
      if (p2 !== 14) begin n_fail++; $display("FAIL hs_phase2_launch: got %0d want 14", p2); end
      n_checks++;
      if (dk !== 21) begin n_fail++; $display("FAIL hs_done_edge: got %0d want 21", dk); end
      @(negedge clock);
   endtask

   task automatic test_converge();
      int dk = -1;
      max_iter = 8'd5; phase_cycles = 64'd0; phase_hs = 4'b0000;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (done) begin dk = k; break; end
         // high across iteration 2 body; only its NEXT (sample 17) may act on it
         converged = (k >= 10) && (k <= 17);
         @(negedge clock);
      end
      converged = 1'b0;
      n_checks++;
      if (dk !== 18) begin n_fail++; $display("FAIL conv_done_edge: got %0d want 18", dk); end
      n_checks++;
      if ({early_stop, iter_count} !== {1'b1, 8'd2}) begin
         n_fail++; $display("FAIL conv_status: es=%b iter=%0d want 1 2", early_stop, iter_count);
      end
      repeat (4) @(negedge clock);
      n_checks++;
      if (early_stop !== 1'b1) begin n_fail++; $display("FAIL conv_hold: es=%b want 1", early_stop); end
      max_iter = 8'd1; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      n_checks++;
      if (early_stop !== 1'b0) begin n_fail++; $display("FAIL conv_clear: es=%b want 0", early_stop); end
      repeat (12) @(negedge clock);
   endtask

   task automatic test_abort();
      int dk, pc, seen_done = 0;
      max_iter = 8'd3; phase_cycles = {4{16'd2}}; phase_hs = 4'b0000;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         abort = (k == 9);
         @(negedge clock);
      end
      abort = 1'b0;
      n_checks++;
      if ({aborted, busy, done, phase_idx, iter_count} !== {1'b1, 1'b0, 1'b0, 2'd0, 8'd0}) begin
         n_fail++; $display("FAIL abort_pulse: ab=%b busy=%b done=%b idx=%0d iter=%0d want 1 0 0 0 0",
                            aborted, busy, done, phase_idx, iter_count);
      end
      for (int k = 0; k < 5; k++) begin
         if (done) seen_done++;
         @(negedge clock);
      end
      n_checks++;
      if ({aborted, seen_done[0]} !== 2'b00 || seen_done != 0) begin
         n_fail++; $display("FAIL abort_after: ab=%b done_count=%0d want 0 0", aborted, seen_done);
      end
      abort = 1'b1;   // ignored in IDLE
      @(negedge clock);
      abort = 1'b0;
      n_checks++;
      if (aborted !== 1'b0) begin n_fail++; $display("FAIL abort_idle: ab=%b want 0", aborted); end
      run_seq(8'd3, {4{16'd2}}, 4'b0000, -1, dk, pc);
      n_checks++;
      if ({dk, iter_count} !== {32'd51, 8'd3}) begin
         n_fail++; $display("FAIL abort_rerun: done_edge=%0d iter=%0d want 51 3", dk, iter_count);
      end
      @(negedge clock);
   endtask

   task automatic test_async_reset();
      max_iter = 8'd3; phase_cycles = {4{16'd2}}; phase_hs = 4'b0000;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (20) @(negedge clock);
      #1 reset = 1'b1;
      #1;
      n_checks++;
      if ({busy, phase_start, phase_idx, iter_count, done, early_stop, aborted, timeout} !== 15'd0) begin
         n_fail++; $display("FAIL async_reset: busy=%b idx=%0d iter=%0d want all 0", busy, phase_idx, iter_count);
      end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

`ifdef PURSUIT_WATCHDOG_EN
   task automatic test_watchdog();
      int tk = -1;
      max_iter = 8'd1; phase_cycles = 64'd0; phase_hs = 4'b0001; phase_ack = 1'b0;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (timeout) begin tk = k; break; end
         @(negedge clock);
      end
      n_checks++;
      if (tk !== 17) begin n_fail++; $display("FAIL wdog_edge: got %0d want 17", tk); end
      n_checks++;
      if ({aborted, busy, done} !== 3'b100) begin
         n_fail++; $display("FAIL wdog_status: ab/busy/done=%b want 100", {aborted, busy, done});
      end
      @(negedge clock);
   endtask
`endif

   initial begin
      test_reset();
      test_all_timed();
      test_phase_walk();
      test_mixed_cycles();
      test_zero_iter();
      test_handshake();
      test_converge();
      test_abort();
      test_async_reset();
`ifdef PURSUIT_WATCHDOG_EN
      test_watchdog();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
